mod_segment_scheduler: RTL and testbench

- Sequences the double-buffered modulation segments: decides which segment the modulation read path (MOD bus SEGMENT select) uses, when it switches, and how many passes run before stopping.
- Sits in the CLK domain between the controller register file (which issues transition requests) and the modulation counter (which reports index advance).
- Transition modes:
  - immediate
  - at the next index wrap
  - on an external trigger edge
- Each transition is followed by either an infinite or a finite number of passes.

---
 rtl/mod_segment_scheduler_pkg.sv | 25 ++
 rtl/mod_segment_scheduler_trig_edge_detect.sv | 21 ++
 rtl/mod_segment_scheduler.sv | 150 +++++++++++++++
 tb/tb_mod_segment_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_segment_scheduler_pkg.sv
// rtl/mod_segment_scheduler_pkg.sv - shared types and constants for the modulation segment scheduler
package mod_segment_scheduler_pkg;

    localparam int NumSegment = 2;
    localparam int SegWidth   = $clog2(NumSegment);
    localparam int IdxWidth   = 15;
    localparam int RepWidth   = 16;

    localparam logic [RepWidth-1:0] RepInfinite = '1;

    typedef enum logic [1:0] {
        TRANSITION_MODE_IMMEDIATE = 2'd0,
        TRANSITION_MODE_SYNC_IDX  = 2'd1,
        TRANSITION_MODE_EXT       = 2'd2,
        TRANSITION_MODE_RSVD      = 2'd3
    } transition_mode_t;

    typedef enum logic [1:0] {
        RUN_INF = 2'd0,
        WAIT    = 2'd1,
        RUN_FIN = 2'd2,
        STOPPED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/mod_segment_scheduler_trig_edge_detect.sv
// rtl/mod_segment_scheduler_trig_edge_detect.sv - rising-edge detector for the external trigger
module trig_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/mod_segment_scheduler.sv
// rtl/mod_segment_scheduler.sv - double-buffered segment sequencer; SEGMENT_SCHED_EXT_TRIG_EN enables trigger mode
module mod_segment_scheduler
    import mod_segment_scheduler_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                UPDATE,
    input  logic [SegWidth-1:0] REQ_SEGMENT,
    input  logic [1:0]          REQ_MODE,
    input  logic [RepWidth-1:0] REQ_REP,
    input  logic                EXT_TRIG,
    input  logic [IdxWidth-1:0] IDX,
    input  logic                IDX_ADV,
    input  logic [IdxWidth-1:0] CYCLE,
    output logic [SegWidth-1:0] SEGMENT,
    output logic                IDX_RST,
    output logic                STOP,
    output logic                BUSY,
    output logic [RepWidth-1:0] LOOP_CNT
);

    sched_state_t     state_q, state_d;
    logic [SegWidth-1:0] seg_q, seg_d, pend_seg_q, pend_seg_d, sw_seg;
    logic [RepWidth-1:0] pend_rep_q, pend_rep_d, run_rep_q, run_rep_d, sw_rep;
    logic [RepWidth-1:0] loop_cnt_q, loop_cnt_d;
    transition_mode_t pend_mode_q, pend_mode_d, mode_eff;
    logic             stop_q, stop_d, idx_rst_q, idx_rst_d;
    logic             wrap, trig_rise, do_switch;

    assign wrap = IDX_ADV && (IDX == CYCLE);

`ifdef SEGMENT_SCHED_EXT_TRIG_EN
    trig_edge_detect u_trig_edge_detect (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .sig_i  (EXT_TRIG),
        .rise_o (trig_rise)
    );
`else
    logic unused_ext_trig;
    assign unused_ext_trig = EXT_TRIG;
    assign trig_rise       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        pend_seg_d  = pend_seg_q;
        pend_rep_d  = pend_rep_q;
        pend_mode_d = pend_mode_q;
        run_rep_d   = run_rep_q;
        loop_cnt_d  = loop_cnt_q;
        stop_d      = stop_q;
        idx_rst_d   = 1'b0;
        do_switch   = 1'b0;
        sw_seg      = pend_seg_q;
        sw_rep      = pend_rep_q;

        // A stopped sequencer accepts any request as an immediate restart.
        mode_eff = transition_mode_t'(REQ_MODE);
        if (state_q == STOPPED) begin
            mode_eff = TRANSITION_MODE_IMMEDIATE;
        end
`ifndef SEGMENT_SCHED_EXT_TRIG_EN
        if (mode_eff == TRANSITION_MODE_EXT) begin
            mode_eff = TRANSITION_MODE_RSVD;
        end
`endif

        // Pass counting continues while a request waits; an exhausted finite run holds.
        if (state_q != STOPPED && !stop_q && wrap) begin
            if (run_rep_q == RepInfinite) begin
                if (loop_cnt_q != RepInfinite) begin
                    loop_cnt_d = loop_cnt_q + 1'b1;
                end
            end else begin
                loop_cnt_d = loop_cnt_q + 1'b1;
                if (loop_cnt_q == run_rep_q) begin
                    stop_d = 1'b1;
                    if (state_q == RUN_FIN) begin
                        state_d = STOPPED;
                    end
                end
            end
        end

        if (UPDATE) begin
            case (mode_eff)
                TRANSITION_MODE_IMMEDIATE: begin
                    do_switch = 1'b1;
                    sw_seg    = REQ_SEGMENT;
                    sw_rep    = REQ_REP;
                end
                TRANSITION_MODE_SYNC_IDX, TRANSITION_MODE_EXT: begin
                    pend_seg_d  = REQ_SEGMENT;
                    pend_rep_d  = REQ_REP;
                    pend_mode_d = mode_eff;
                    state_d     = WAIT;
                end
                default: ;
            endcase
        end else if (state_q == WAIT) begin
            case (pend_mode_q)
                TRANSITION_MODE_SYNC_IDX: do_switch = wrap;
                TRANSITION_MODE_EXT:      do_switch = trig_rise;
                default: ;
            endcase
        end

        if (do_switch) begin
            seg_d      = sw_seg;
            idx_rst_d  = 1'b1;
            loop_cnt_d = '0;
            stop_d     = 1'b0;
            run_rep_d  = sw_rep;
            state_d    = (sw_rep == RepInfinite) ? RUN_INF : RUN_FIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= RUN_INF;
            seg_q       <= '0;
            pend_seg_q  <= '0;
            pend_rep_q  <= RepInfinite;
            pend_mode_q <= TRANSITION_MODE_IMMEDIATE;
            run_rep_q   <= RepInfinite;
            loop_cnt_q  <= '0;
            stop_q      <= 1'b0;
            idx_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            pend_seg_q  <= pend_seg_d;
            pend_rep_q  <= pend_rep_d;
            pend_mode_q <= pend_mode_d;
            run_rep_q   <= run_rep_d;
            loop_cnt_q  <= loop_cnt_d;
            stop_q      <= stop_d;
            idx_rst_q   <= idx_rst_d;
        end
    end

    assign SEGMENT  = seg_q;
    assign IDX_RST  = idx_rst_q;
    assign STOP     = stop_q;
    assign BUSY     = (state_q == WAIT);
    assign LOOP_CNT = loop_cnt_q;

endmodule

// File: tb/tb_mod_segment_scheduler.sv
// tb/tb_mod_segment_scheduler.sv - scoreboard bench for mod_segment_scheduler
module tb_mod_segment_scheduler;

`ifdef SEGMENT_SCHED_EXT_TRIG_EN
    localparam logic ExtEn = 1'b1;
`else
    localparam logic ExtEn = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        UPDATE = 1'b0;
    logic [0:0]  REQ_SEGMENT = 1'b0;
    logic [1:0]  REQ_MODE = 2'd0;
    logic [15:0] REQ_REP = 16'hFFFF;
    logic        EXT_TRIG = 1'b0;
    logic [14:0] IDX = '0;
    logic        IDX_ADV = 1'b0;
    logic [14:0] CYCLE = 15'd3;
    logic [0:0]  SEGMENT;
    logic        IDX_RST;
    logic        STOP;
    logic        BUSY;
    logic [15:0] LOOP_CNT;

    mod_segment_scheduler dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .UPDATE      (UPDATE),
        .REQ_SEGMENT (REQ_SEGMENT),
        .REQ_MODE    (REQ_MODE),
        .REQ_REP     (REQ_REP),
        .EXT_TRIG    (EXT_TRIG),
        .IDX         (IDX),
        .IDX_ADV     (IDX_ADV),
        .CYCLE       (CYCLE),
        .SEGMENT     (SEGMENT),
        .IDX_RST     (IDX_RST),
        .STOP        (STOP),
        .BUSY        (BUSY),
        .LOOP_CNT    (LOOP_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // {SEGMENT, IDX_RST, STOP, BUSY, LOOP_CNT}
    logic [19:0] exp_q[$];
    int          cyc_q[$];
    string       nm_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    always @(negedge CLK) begin
        logic [19:0] act;
        act = {SEGMENT, IDX_RST, STOP, BUSY, LOOP_CNT};
        while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: never sampled, wanted at cycle %0d", nm_q[0], cyc_q[0]);
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            void'(nm_q.pop_front());
        end
        if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
            n_chk++;
            if (act !== exp_q[0]) begin
                n_fail++;
                $display("FAIL %s: got seg=%0d rst=%0d stop=%0d busy=%0d loop=%0d, wanted seg=%0d rst=%0d stop=%0d busy=%0d loop=%0d",
                         nm_q[0], act[19], act[18], act[17], act[16], act[15:0],
                         exp_q[0][19], exp_q[0][18], exp_q[0][17], exp_q[0][16], exp_q[0][15:0]);
            end
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            void'(nm_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        UPDATE  = 1'b0;
        IDX_ADV = 1'b0;
    endtask

    task automatic expect_next(input string nm, input logic s, input logic r, input logic st,
                               input logic b, input logic [15:0] lc);
        exp_q.push_back({s, r, st, b, lc});
        cyc_q.push_back(cyc + 1);
        nm_q.push_back(nm);
        tick();
    endtask

    task automatic req(input logic s, input logic [1:0] m, input logic [15:0] rep);
        UPDATE      = 1'b1;
        REQ_SEGMENT = s;
        REQ_MODE    = m;
        REQ_REP     = rep;
    endtask

    task automatic adv(input int i);
        IDX     = 15'(i);
        IDX_ADV = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge CLK);
        #1;
        // reset held three cycles
        tick();
        tick();
        expect_next("reset", 0, 0, 0, 0, 0);
        RST_N = 1'b1;
        expect_next("idle", 0, 0, 0, 0, 0);

        // immediate switch
        req(1, 2'd0, 16'hFFFF);
        expect_next("imm_switch", 1, 1, 0, 0, 0);
        expect_next("imm_pulse_end", 1, 0, 0, 0, 0);

        // sync on wrap, CYCLE=3
        adv(0);                 expect_next("sync_idx0", 1, 0, 0, 0, 0);
        adv(1); req(0, 2'd1, 16'hFFFF);
                                expect_next("sync_busy", 1, 0, 0, 1, 0);
        adv(2);                 expect_next("sync_busy2", 1, 0, 0, 1, 0);
        adv(3);                 expect_next("sync_switch", 0, 1, 0, 0, 0);
        adv(0);                 expect_next("sync_after", 0, 0, 0, 0, 0);
        adv(1);                 expect_next("sync_run1", 0, 0, 0, 0, 0);
        adv(2);                 expect_next("sync_run2", 0, 0, 0, 0, 0);
        adv(3); req(1, 2'd1, 16'hFFFF);
                                expect_next("sync_update_on_wrap", 0, 0, 0, 1, 1);
        adv(0);                 expect_next("sync_wait0", 0, 0, 0, 1, 1);
        adv(1);                 expect_next("sync_wait1", 0, 0, 0, 1, 1);
        adv(2);                 expect_next("sync_wait2", 0, 0, 0, 1, 1);
        adv(3);                 expect_next("sync_full_pass", 1, 1, 0, 0, 0);
        expect_next("sync_idle", 1, 0, 0, 0, 0);

        // finite run, rep=2, CYCLE=4
        CYCLE = 15'd4;
        req(1, 2'd0, 16'd2);    expect_next("fin_switch", 1, 1, 0, 0, 0);
        adv(2);                 expect_next("fin_nowrap", 1, 0, 0, 0, 0);
        adv(4);                 expect_next("fin_loop1", 1, 0, 0, 0, 1);
        adv(4);                 expect_next("fin_loop2", 1, 0, 0, 0, 2);
        adv(4);                 expect_next("fin_stop", 1, 0, 1, 0, 3);
        adv(4);                 expect_next("fin_hold", 1, 0, 1, 0, 3);
        req(0, 2'd1, 16'hFFFF); expect_next("stopped_update_imm", 0, 1, 0, 0, 0);

        // external trigger
        EXT_TRIG = 1'b1;        expect_next("ext_pre", 0, 0, 0, 0, 0);
        req(1, 2'd2, 16'hFFFF); expect_next("ext_req", 0, 0, 0, ExtEn, 0);
                                expect_next("ext_level_hold", 0, 0, 0, ExtEn, 0);
        EXT_TRIG = 1'b0;        expect_next("ext_low", 0, 0, 0, ExtEn, 0);
        EXT_TRIG = 1'b1;        expect_next("ext_switch", ExtEn, ExtEn, 0, 0, 0);
                                expect_next("ext_after", ExtEn, 0, 0, 0, 0);

        // overwrite pending request, CYCLE=3
        CYCLE = 15'd3;
        adv(1); req(1, 2'd1, 16'hFFFF);
                                expect_next("ovw_first", ExtEn, 0, 0, 1, 0);
        adv(2); req(0, 2'd1, 16'hFFFF);
                                expect_next("ovw_second", ExtEn, 0, 0, 1, 0);
        adv(3);                 expect_next("ovw_switch", 0, 1, 0, 0, 0);

        // reset discards pending request
        req(1, 2'd1, 16'hFFFF); expect_next("rst_pending", 0, 0, 0, 1, 0);
        RST_N = 1'b0;           expect_next("rst_busy_clear", 0, 0, 0, 0, 0);
        RST_N = 1'b1;
        adv(3);                 expect_next("rst_no_switch", 0, 0, 0, 0, 1);

        // reserved mode ignored
        req(1, 2'd3, 16'd5);    expect_next("rsvd_ignored", 0, 0, 0, 0, 1);
                                expect_next("rsvd_after", 0, 0, 0, 0, 1);

        tick();
        tick();
        if (cyc_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, wanted 0", cyc_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
